// File: rtl/nonrestoring_div_p.sv
// Multi-cycle unsigned non-restoring divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit
// divisor, one quotient bit per clock, with divide-by-zero and quotient-overflow detection.
module nonrestoring_div_p #(
  parameter int WIDTH = 2048,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_hi,
  input  logic [WIDTH-1:0] dividend_lo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt;
  logic signed [WIDTH:0] acc;
  logic [WIDTH-1:0]      q_reg;
  logic [WIDTH-1:0]      d_reg;
  logic [WIDTH-1:0]      lo_reg;
  logic                  sub_flag;
  logic                  err;
  logic                  accept;
  logic                  start_err;
  logic signed [WIDTH:0] acc_step;
  logic signed [WIDTH:0] acc_fix;

  // One non-restoring iteration: shift in the next dividend bit, then add or subtract D.
  // WIDTH+1 bit wraparound is harmless because the true result lies in [-D, D).
  function automatic logic signed [WIDTH:0] nr_step(input logic signed [WIDTH:0] a,
                                                    input logic             qin,
                                                    input logic [WIDTH-1:0] d,
                                                    input logic             sub);
    logic signed [WIDTH:0] sh;
    logic signed [WIDTH:0] dd;
    sh = {a[WIDTH-1:0], qin};
    dd = {1'b0, d};
    return sub ? (sh - dd) : (sh + dd);
  endfunction

  function automatic logic signed [WIDTH:0] nr_restore(input logic signed [WIDTH:0] a,
                                                       input logic [WIDTH-1:0] d);
    logic signed [WIDTH:0] dd;
    dd = {1'b0, d};
    return a[WIDTH] ? (a + dd) : a;
  endfunction

  // A start arriving during the done pulse is dropped so results are seen first.
  assign accept    = (state == IDLE) && start && !done;
  assign start_err = (divisor == '0) || (dividend_hi >= divisor);
  assign acc_step  = nr_step(acc, q_reg[WIDTH-1], d_reg, sub_flag);
  assign acc_fix   = nr_restore(acc, d_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Error paths pass through FIX so both flavours share one completion sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = start_err ? FIX : RUN;
      RUN:  if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      lo_reg      <= '0;
      sub_flag    <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy        <= 1'b1;
            d_reg       <= divisor;
            lo_reg      <= dividend_lo;
            acc         <= {1'b0, dividend_hi};
            q_reg       <= dividend_lo;
            cnt         <= CNT_W'(WIDTH);
            sub_flag    <= 1'b1;
            err         <= start_err;
            div_by_zero <= (divisor == '0);
            overflow    <= (divisor != '0) && (dividend_hi >= divisor);
          end
        end
        RUN: begin
          acc      <= acc_step;
          q_reg    <= {q_reg[WIDTH-2:0], ~acc_step[WIDTH]};
          sub_flag <= ~acc_step[WIDTH];
          cnt      <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (err) begin
            quotient  <= '1;
            remainder <= lo_reg;
          end else begin
            acc       <= acc_fix;
            quotient  <= q_reg;
            remainder <= acc_fix[WIDTH-1:0];
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_div_p.sv
// Directed and randomized checks of nonrestoring_div_p at WIDTH=8 and WIDTH=16.
module tb_nonrestoring_div_p;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0;
  logic [7:0] hi8 = '0, lo8 = '0, d8 = '0;
  logic [7:0] q8, r8;
  logic       busy8, done8, dz8, ov8;

  logic        start16 = 1'b0;
  logic [15:0] hi16 = '0, lo16 = '0, d16 = '0;
  logic [15:0] q16, r16;
  logic        busy16, done16, dz16, ov16;

  int total = 0;
  int bad   = 0;

  nonrestoring_div_p #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .dividend_hi(hi8), .dividend_lo(lo8),
    .divisor(d8), .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
    .div_by_zero(dz8), .overflow(ov8)
  );

  nonrestoring_div_p #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16), .dividend_hi(hi16), .dividend_lo(lo16),
    .divisor(d16), .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
    .div_by_zero(dz16), .overflow(ov16)
  );

  // Launches one 8-bit division, returns edges from accept to done, checks the pulse is single.
  task automatic op8(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] d,
                     output int lat);
    start8 = 1'b1; hi8 = hi; lo8 = lo; d8 = d;
    @(posedge clk); #1;
    start8 = 1'b0; hi8 = 8'hA5; lo8 = 8'h3C; d8 = 8'h11;
    total++;
    if (busy8 !== 1'b1) begin bad++; $display("FAIL busy8_after_accept: got %b want 1", busy8); end
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL busy8_at_done: got %b want 0", busy8); end
    @(posedge clk); #1;
    total++;
    if (done8 !== 1'b0) begin bad++; $display("FAIL done8_single_pulse: got %b want 0", done8); end
  endtask

  task automatic op16(input logic [15:0] hi, input logic [15:0] lo, input logic [15:0] d,
                      output int lat);
    start16 = 1'b1; hi16 = hi; lo16 = lo; d16 = d;
    @(posedge clk); #1;
    start16 = 1'b0; hi16 = 16'h5A5A; lo16 = 16'hC3C3; d16 = 16'h0101;
    lat = 0;
    while (done16 !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy8, done8, q8, r8, dz8, ov8} !== 20'h0) begin
      bad++; $display("FAIL reset8_outputs: got %h want 0", {busy8, done8, q8, r8, dz8, ov8});
    end
    total++;
    if ({busy16, done16, q16, r16, dz16, ov16} !== 36'h0) begin
      bad++; $display("FAIL reset16_outputs: got %h want 0", {busy16, done16, q16, r16, dz16, ov16});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat;
    op8(8'd0, 8'd100, 8'd7, lat);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL basic_latency: got %0d want 10", lat); end
    total++;
    if ({q8, r8, dz8, ov8} !== {8'd14, 8'd2, 2'b00}) begin
      bad++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b ov=%b want q=14 r=2 dz=0 ov=0", q8, r8, dz8, ov8);
    end
  endtask

  task automatic test_max_dividend;
    int lat;
    op8(8'hFE, 8'hFF, 8'hFF, lat);
    total++;
    if ({q8, r8, dz8, ov8} !== {8'hFF, 8'hFE, 2'b00}) begin
      bad++; $display("FAIL max_dividend: got q=%h r=%h dz=%b ov=%b want q=ff r=fe dz=0 ov=0", q8, r8, dz8, ov8);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    op8(8'h00, 8'h5A, 8'h00, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL divzero_latency: got %0d want 2", lat); end
    total++;
    if ({q8, r8, dz8, ov8} !== {8'hFF, 8'h5A, 2'b10}) begin
      bad++; $display("FAIL divzero_result: got q=%h r=%h dz=%b ov=%b want q=ff r=5a dz=1 ov=0", q8, r8, dz8, ov8);
    end
  endtask

  task automatic test_overflow;
    int lat;
    op8(8'd7, 8'd0, 8'd7, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL overflow_latency: got %0d want 2", lat); end
    total++;
    if ({q8, r8, dz8, ov8} !== {8'hFF, 8'h00, 2'b01}) begin
      bad++; $display("FAIL overflow_result: got q=%h r=%h dz=%b ov=%b want q=ff r=00 dz=0 ov=1", q8, r8, dz8, ov8);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    start8 = 1'b1; hi8 = 8'd0; lo8 = 8'd200; d8 = 8'd3;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start8 = 1'b1; d8 = 8'd5;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 4;
    while (done8 !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat !== 10) begin bad++; $display("FAIL ignore_latency: got %0d want 10", lat); end
    total++;
    if ({q8, r8, dz8, ov8} !== {8'd66, 8'd2, 2'b00}) begin
      bad++; $display("FAIL ignore_result: got q=%0d r=%0d want q=66 r=2", q8, r8);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    // Hold start through the done cycle: dropped there, accepted on the following edge.
    start8 = 1'b1; hi8 = 8'h12; lo8 = 8'h34; d8 = 8'h56;
    @(posedge clk); #1;
    total++;
    if (busy8 !== 1'b0) begin bad++; $display("FAIL start_during_done: got busy=%b want 0", busy8); end
    @(posedge clk); #1;
    start8 = 1'b0;
    total++;
    if (busy8 !== 1'b1) begin bad++; $display("FAIL start_after_done: got busy=%b want 1", busy8); end
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++;
    if ({lat[7:0], q8, r8} !== {8'd10, 8'd54, 8'd16}) begin
      bad++; $display("FAIL back_to_back1: got lat=%0d q=%0d r=%0d want lat=10 q=54 r=16", lat, q8, r8);
    end
    @(posedge clk); #1;
    op8(8'd0, 8'd255, 8'd16, lat);
    total++;
    if ({lat[7:0], q8, r8} !== {8'd10, 8'd15, 8'd15}) begin
      bad++; $display("FAIL back_to_back2: got lat=%0d q=%0d r=%0d want lat=10 q=15 r=15", lat, q8, r8);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int seen;
    op16(16'h0000, 16'd1000, 16'd7, lat);
    total++;
    if ({q16, r16} !== {16'd142, 16'd6}) begin
      bad++; $display("FAIL w16_pre_reset: got q=%0d r=%0d want q=142 r=6", q16, r16);
    end
    start16 = 1'b1; hi16 = 16'h0001; lo16 = 16'h0000; d16 = 16'h0003;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++;
    if ({busy16, done16, q16, r16, dz16, ov16} !== 36'h0) begin
      bad++; $display("FAIL w16_async_reset: got %h want 0", {busy16, done16, q16, r16, dz16, ov16});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (done16 === 1'b1 || busy16 === 1'b1) seen++; end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL w16_abandoned: got %0d active cycles want 0", seen); end
    op16(16'h0001, 16'h0000, 16'h0003, lat);
    total++;
    if ({lat[7:0], q16, r16, dz16, ov16} !== {8'd18, 16'd21845, 16'd1, 2'b00}) begin
      bad++; $display("FAIL w16_after_reset: got lat=%0d q=%0d r=%0d want lat=18 q=21845 r=1", lat, q16, r16);
    end
  endtask

  task automatic test_random8;
    int lat;
    logic [7:0]  d, hi, lo;
    logic [15:0] chk;
    for (int i = 0; i < 300; i++) begin
      d  = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, 255) % d);
      lo = 8'($urandom_range(0, 255));
      op8(hi, lo, d, lat);
      chk = 16'(q8) * 16'(d) + 16'(r8);
      total++;
      if (chk !== {hi, lo} || r8 >= d || dz8 !== 1'b0 || ov8 !== 1'b0 || lat !== 10) begin
        bad++; $display("FAIL rand8: %h/%h got q=%h r=%h lat=%0d", {hi, lo}, d, q8, r8, lat);
      end
    end
  endtask

  task automatic test_random16;
    int lat;
    logic [15:0] d, hi, lo;
    logic [31:0] chk;
    for (int i = 0; i < 300; i++) begin
      d  = 16'($urandom_range(1, 65535));
      hi = 16'($urandom_range(0, 65535) % d);
      lo = 16'($urandom_range(0, 65535));
      op16(hi, lo, d, lat);
      chk = 32'(q16) * 32'(d) + 32'(r16);
      total++;
      if (chk !== {hi, lo} || r16 >= d || dz16 !== 1'b0 || ov16 !== 1'b0 || lat !== 18) begin
        bad++; $display("FAIL rand16: %h/%h got q=%h r=%h lat=%0d", {hi, lo}, d, q16, r16, lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max_dividend;
    test_div_zero;
    test_overflow;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_run;
    test_random8;
    test_random16;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
